// File: rtl/mps_intr_ctrl_if.sv
// AXI-lite register port of the interrupt controller.
// master drives requests, slave answers them.
interface mps_intr_ctrl_if;
  logic        awvalid;
  logic        awready;
  logic [7:0]  awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [7:0]  araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );
endinterface

// File: rtl/mps_intr_ctrl.sv
// Interrupt controller: per-port mask and line routing,
// per-line hold-off moderation, AXI-lite config slave.
module mps_intr_ctrl #(
  parameter int          PORT_NUM    = 8,
  parameter int          INT_LINES   = 4,
  parameter int          HOLDOFF_W   = 16,
  parameter int unsigned HOLDOFF_RST = 0
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [PORT_NUM-1:0]  port_irq,
  mps_intr_ctrl_if.slave       axi_s,
  output logic [INT_LINES-1:0] intr_req
);

  localparam logic [5:0] A_PEND  = 6'h00;
  localparam logic [5:0] A_EN    = 6'h01;
  localparam logic [5:0] A_ROUTE = 6'h02;
  localparam logic [5:0] A_HOLD  = 6'h03;
  localparam logic [5:0] A_LINES = 6'h04;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int RW = 2 * PORT_NUM;

  function automatic logic [RW-1:0] route_init();
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < PORT_NUM; i++)
      r[2*i +: 2] = 2'(i % INT_LINES);
    return r;
  endfunction

  localparam logic [RW-1:0] ROUTE_RST = route_init();

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLD
  } line_st_e;

  logic [PORT_NUM-1:0]  irq_q;
  logic [PORT_NUM-1:0]  enable_q;
  logic [RW-1:0]        route_q;
  logic [HOLDOFF_W-1:0] holdoff_q;
  logic [INT_LINES-1:0] act;

  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  logic        wr_fire;
  logic        rd_fire;
  logic [5:0]  wr_idx;
  logic [5:0]  rd_idx;
  logic [31:0] wmask;
  logic        wr_en;
  logic        wr_rt;
  logic        wr_ho;
  logic        wr_ok;
  logic [31:0] rd_word;
  logic        rd_ok;
  logic        unused_bits;

  // Handshakes are held off while reset is asserted.
  assign wr_fire = axi_s.awvalid & axi_s.wvalid
                 & ~bvalid_q & ~areset;
  assign rd_fire = axi_s.arvalid & ~rvalid_q & ~areset;

  assign wr_idx = axi_s.awaddr[7:2];
  assign rd_idx = axi_s.araddr[7:2];

  assign wmask = {{8{axi_s.wstrb[3]}},
                  {8{axi_s.wstrb[2]}},
                  {8{axi_s.wstrb[1]}},
                  {8{axi_s.wstrb[0]}}};

  assign unused_bits = ^{axi_s.awaddr[1:0],
                         axi_s.araddr[1:0],
                         axi_s.wdata, wmask};

  assign axi_s.awready = wr_fire;
  assign axi_s.wready  = wr_fire;
  assign axi_s.bvalid  = bvalid_q;
  assign axi_s.bresp   = bresp_q;
  assign axi_s.arready = rd_fire;
  assign axi_s.rvalid  = rvalid_q;
  assign axi_s.rdata   = rdata_q;
  assign axi_s.rresp   = rresp_q;

  always_comb begin
    wr_en = 1'b0;
    wr_rt = 1'b0;
    wr_ho = 1'b0;
    wr_ok = 1'b0;
    unique case (1'b1)
      (wr_idx == A_EN): begin
        wr_en = wr_fire;
        wr_ok = 1'b1;
      end
      (wr_idx == A_ROUTE): begin
        wr_rt = wr_fire;
        wr_ok = 1'b1;
      end
      (wr_idx == A_HOLD): begin
        wr_ho = wr_fire;
        wr_ok = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_word = '0;
    rd_ok   = 1'b1;
    unique case (1'b1)
      (rd_idx == A_PEND):  rd_word = 32'(irq_q);
      (rd_idx == A_EN):    rd_word = 32'(enable_q);
      (rd_idx == A_ROUTE): rd_word = 32'(route_q);
      (rd_idx == A_HOLD):  rd_word = 32'(holdoff_q);
      (rd_idx == A_LINES): rd_word = 32'(intr_req);
      default:             rd_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      irq_q     <= '0;
      enable_q  <= '0;
      route_q   <= ROUTE_RST;
      holdoff_q <= HOLDOFF_W'(HOLDOFF_RST);
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      irq_q <= port_irq;
      if (wr_en)
        enable_q <= (enable_q & ~wmask[PORT_NUM-1:0])
                  | (axi_s.wdata[PORT_NUM-1:0]
                     & wmask[PORT_NUM-1:0]);
      if (wr_rt)
        route_q <= (route_q & ~wmask[RW-1:0])
                 | (axi_s.wdata[RW-1:0] & wmask[RW-1:0]);
      if (wr_ho)
        holdoff_q <= (holdoff_q & ~wmask[HOLDOFF_W-1:0])
                   | (axi_s.wdata[HOLDOFF_W-1:0]
                      & wmask[HOLDOFF_W-1:0]);
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? OKAY : SLVERR;
      end else if (axi_s.bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_ok ? OKAY : SLVERR;
      end else if (axi_s.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar L = 0; L < INT_LINES; L++) begin : g_line
    logic [PORT_NUM-1:0]  sel;
    line_st_e             st_q;
    line_st_e             st_d;
    logic [HOLDOFF_W-1:0] cnt_q;
    logic [HOLDOFF_W-1:0] cnt_d;
    logic                 req_q;

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_sel
      assign sel[i] = (route_q[2*i +: 2] == 2'(L));
    end

    assign act[L]      = |(irq_q & enable_q & sel);
    assign intr_req[L] = req_q;

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        req_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        req_q <= (st_d == ASSERT);
      end
    end

    // HOLDOFF is sampled only on entry to HOLD.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
        IDLE: begin
          if (act[L])
            st_d = ASSERT;
        end
        ASSERT: begin
          if (!act[L]) begin
            if (holdoff_q == '0) begin
              st_d = IDLE;
            end else begin
              st_d  = HOLD;
              cnt_d = holdoff_q;
            end
          end
        end
        HOLD: begin
          cnt_d = cnt_q - HOLDOFF_W'(1);
          if (cnt_q <= HOLDOFF_W'(1))
            st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
  end

endmodule
